// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the pipeline control logic.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter with synchronous clear.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush/halt sequencer for an in-order core.
// Define PIPE_PERF_EN to build in the stall/flush performance counters.
module pipeline_controller
    import cpu_types_pkg::*;
#(
    parameter int NSTAGES   = 5,
    parameter int MEM_STAGE = 3,
    parameter int PERF_W    = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dmem_req,
    input  logic               load_use,
    input  logic               branch_taken,
    input  logic               halt_dec,
    output logic               pc_en,
    output logic [NSTAGES-2:0] latch_en,
    output logic [NSTAGES-2:0] latch_flush,
    output logic [NSTAGES-1:0] valid,
    output logic               halt,
    output logic [PERF_W-1:0]  stall_cnt,
    output logic [PERF_W-1:0]  flush_cnt
);

    pipe_state_t        r_state;
    pipe_state_t        w_state_nxt;
    logic [NSTAGES-1:0] r_valid;
    logic [NSTAGES-1:2] r_tok;
    logic               r_halt;
    logic               w_mem_stall;
    logic               w_pc_en;
    logic               w_load_tok;
    logic               w_tok_out;
    logic [NSTAGES-2:0] w_en;
    logic [NSTAGES-2:0] w_fl;

    assign w_mem_stall = r_valid[MEM_STAGE] & dmem_req & ~dhit;

    always_comb begin
        w_pc_en     = 1'b1;
        w_en        = '1;
        w_fl        = '0;
        w_state_nxt = r_state;
        if (w_mem_stall) begin
            w_pc_en = 1'b0;
            for (int k = 0; k < MEM_STAGE; k++) begin
                w_en[k] = 1'b0;
            end
            w_fl[MEM_STAGE] = 1'b1;
        end else if (load_use) begin
            w_pc_en = 1'b0;
            w_en[0] = 1'b0;
            w_fl[1] = 1'b1;
        end else if (branch_taken) begin
            w_fl[0] = 1'b1;
        end else if (!ihit) begin
            w_pc_en = 1'b0;
            w_fl[0] = 1'b1;
        end
        // Draining: no new fetches, whatever ID resolves.
        if (r_state == DRAIN) begin
            w_pc_en = 1'b0;
            w_fl[0] = 1'b1;
        end
        if (r_state == HALTED) begin
            w_pc_en = 1'b0;
            w_en    = '0;
            w_fl    = '0;
        end
        if (!nRST) begin
            w_pc_en = 1'b0;
            w_en    = '0;
            w_fl    = '1;
        end
        w_load_tok = (r_state == RUN) & halt_dec & r_valid[1]
                   & w_en[1] & ~w_fl[1];
        w_tok_out  = (r_state == DRAIN) & r_tok[NSTAGES-1];
        case (r_state)
            RUN:     if (w_load_tok) w_state_nxt = DRAIN;
            DRAIN:   if (w_tok_out)  w_state_nxt = HALTED;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
            r_valid <= '0;
            r_tok   <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid[0] <= (w_state_nxt == RUN);
            for (int k = 0; k < NSTAGES-1; k++) begin
                if (w_en[k]) r_valid[k+1] <= ~w_fl[k] & r_valid[k];
            end
            if (w_en[1]) r_tok[2] <= w_load_tok;
            for (int k = 2; k < NSTAGES-1; k++) begin
                if (w_en[k]) r_tok[k+1] <= ~w_fl[k] & r_tok[k];
            end
            if (w_tok_out) r_halt <= 1'b1;
        end
    end

    assign pc_en       = w_pc_en;
    assign latch_en    = w_en;
    assign latch_flush = w_fl;
    assign valid       = r_valid;
    assign halt        = r_halt;

`ifdef PIPE_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = (r_state != HALTED) & ~w_pc_en;
    assign w_flush_inc = (r_state != HALTED) & (|w_fl);

    perf_counter #(.W(PERF_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .i_inc (w_stall_inc),
        .i_clr (1'b0),
        .o_cnt (stall_cnt)
    );

    perf_counter #(.W(PERF_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .i_inc (w_flush_inc),
        .i_clr (1'b0),
        .o_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: directed windows, negedge monitor.
module tb_pipeline_controller;

    localparam int NS = 5;
    localparam int PW = 4;
`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ihit = 1'b1;
    logic          dhit = 1'b0;
    logic          dmem_req = 1'b0;
    logic          load_use = 1'b0;
    logic          branch_taken = 1'b0;
    logic          halt_dec = 1'b0;
    logic          pc_en;
    logic [NS-2:0] latch_en;
    logic [NS-2:0] latch_flush;
    logic [NS-1:0] valid;
    logic          halt;
    logic [PW-1:0] stall_cnt;
    logic [PW-1:0] flush_cnt;

    pipeline_controller #(
        .NSTAGES   (NS),
        .MEM_STAGE (3),
        .PERF_W    (PW)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .dmem_req     (dmem_req),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .halt_dec     (halt_dec),
        .pc_en        (pc_en),
        .latch_en     (latch_en),
        .latch_flush  (latch_flush),
        .valid        (valid),
        .halt         (halt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    localparam int S_PC = 0, S_EN = 1, S_FL = 2, S_VLD = 3;
    localparam int S_HLT = 4, S_SC = 5, S_FC = 6;

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            S_PC:    return {31'b0, pc_en};
            S_EN:    return {28'b0, latch_en};
            S_FL:    return {28'b0, latch_flush};
            S_VLD:   return {27'b0, valid};
            S_HLT:   return {31'b0, halt};
            S_SC:    return {28'b0, stall_cnt};
            S_FC:    return {28'b0, flush_cnt};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp(input int sel, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic win();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit ih, input bit dh, input bit dr,
                         input bit lu, input bit bt, input bit hd);
        ihit         = ih;
        dhit         = dh;
        dmem_req     = dr;
        load_use     = lu;
        branch_taken = bt;
        halt_dec     = hd;
    endtask

    task automatic chk_reset(input string n);
        exp(S_PC,  0,     {n, "_pc_en"});
        exp(S_EN,  0,     {n, "_latch_en"});
        exp(S_FL,  4'hF,  {n, "_flush"});
        exp(S_VLD, 0,     {n, "_valid"});
        exp(S_HLT, 0,     {n, "_halt"});
        exp(S_SC,  0,     {n, "_stall_cnt"});
        exp(S_FC,  0,     {n, "_flush_cnt"});
    endtask

    // Monitor: compares every expectation queued for the current window.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge CLK);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                a = sig(e.sel);
                total++;
                if (e.cyc != cyc) begin
                    bad++;
                    $display("FAIL %s: stale check from cyc %0d at cyc %0d",
                             e.name, e.cyc, cyc);
                end else if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %0h want %0h (cyc %0d)",
                             e.name, a, e.val, cyc);
                end
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        win();
        chk_reset("rst0");
        win();
        nRST = 1'b1;
        exp(S_VLD, 0, "rel_valid");
        exp(S_PC,  1, "rel_pc_en");
        win();
        exp(S_VLD, 5'b00001, "first_edge_valid");
        win(); win(); win(); win();
        exp(S_VLD, 5'b11111, "idle_valid");
        exp(S_PC,  1,        "idle_pc_en");
        exp(S_FL,  0,        "idle_flush");
        exp(S_EN,  4'hF,     "idle_en");

        win();
        drive(1, 0, 1, 0, 0, 0);
        exp(S_PC, 0,       "mst_pc_en");
        exp(S_EN, 4'b1000, "mst_en");
        exp(S_FL, 4'b1000, "mst_flush");
        win();
        exp(S_PC,  0,        "mst_pc_en2");
        exp(S_VLD, 5'b01111, "mst_valid");
        win();
        exp(S_PC, 0, "mst_pc_en3");
        win();
        drive(1, 1, 1, 0, 0, 0);
        exp(S_PC, 1,            "mst_end_pc_en");
        exp(S_SC, PERF ? 3 : 0, "mst_stall_cnt");
        win();
        drive(1, 0, 0, 0, 0, 0);
        exp(S_VLD, 5'b11111, "mst_refill");

        win();
        drive(1, 0, 0, 1, 1, 0);
        exp(S_PC, 0,       "lu_pc_en");
        exp(S_EN, 4'b1110, "lu_en");
        exp(S_FL, 4'b0010, "lu_flush");
        win();
        drive(1, 0, 0, 0, 1, 0);
        exp(S_PC,  1,        "br_pc_en");
        exp(S_FL,  4'b0001,  "br_flush");
        exp(S_VLD, 5'b11011, "br_valid");
        win();
        drive(1, 0, 0, 0, 0, 0);
        exp(S_VLD, 5'b10101,     "post_br_valid");
        exp(S_SC,  PERF ? 4 : 0, "br_stall_cnt");
        exp(S_FC,  PERF ? 5 : 0, "br_flush_cnt");
        win();
        drive(0, 0, 0, 0, 0, 0);
        exp(S_PC, 0,       "imiss_pc_en");
        exp(S_FL, 4'b0001, "imiss_flush");
        exp(S_EN, 4'hF,    "imiss_en");
        win();
        drive(1, 0, 0, 0, 0, 0);
        exp(S_SC, PERF ? 5 : 0, "imiss_stall_cnt");
        exp(S_FC, PERF ? 6 : 0, "imiss_flush_cnt");
        win(); win(); win();
        win();
        exp(S_VLD, 5'b11111, "pre_halt_valid");
        drive(1, 0, 0, 0, 0, 1);
        exp(S_PC, 1, "halt_dec_pc_en");

        win();
        drive(1, 0, 0, 0, 1, 0);
        exp(S_PC,  0,        "drain_pc_en");
        exp(S_FL,  4'b0001,  "drain_flush");
        exp(S_VLD, 5'b11110, "drain_valid");
        exp(S_HLT, 0,        "drain_halt");
        win();
        drive(1, 0, 0, 0, 0, 1);
        exp(S_PC,  0,        "drain_pc_en2");
        exp(S_VLD, 5'b11100, "drain_valid2");
        win();
        drive(1, 0, 0, 0, 0, 0);
        exp(S_VLD, 5'b11000, "drain_valid3");
        exp(S_HLT, 0,        "drain_halt3");
        win();
        exp(S_HLT, 1,        "halted");
        exp(S_PC,  0,        "halted_pc_en");
        exp(S_EN,  0,        "halted_en");
        exp(S_VLD, 5'b10000, "halted_valid");
        win();
        drive(1, 0, 0, 0, 1, 0);
        exp(S_PC,  0,            "halted_br_pc_en");
        exp(S_EN,  0,            "halted_br_en");
        exp(S_VLD, 5'b10000,     "halted_frozen");
        exp(S_HLT, 1,            "halted_sticky");
        exp(S_SC,  PERF ? 8 : 0, "halted_stall_cnt");
        exp(S_FC,  PERF ? 9 : 0, "halted_flush_cnt");

        win();
        drive(1, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        chk_reset("rst_halted");
        win();
        nRST = 1'b1;
        exp(S_VLD, 0, "rel2_valid");
        win();
        exp(S_VLD, 5'b00001, "rel2_first_edge");
        win(); win(); win();
        win();
        drive(1, 0, 0, 0, 0, 1);
        exp(S_VLD, 5'b11111, "refill2_valid");
        win();
        drive(1, 0, 1, 0, 0, 0);
        exp(S_PC, 0,       "drain_mst_pc_en");
        exp(S_EN, 4'b1000, "drain_mst_en");
        exp(S_FL, 4'b1001, "drain_mst_flush");
        win();
        nRST = 1'b0;
        chk_reset("rst_drain");
        win();
        nRST = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        exp(S_VLD, 0, "rel3_valid");
        exp(S_PC,  1, "rel3_pc_en");
        win();
        exp(S_VLD, 5'b00001, "rel3_first_edge");
        exp(S_HLT, 0,        "rel3_halt");
        exp(S_SC,  0,        "rel3_stall_cnt");

        for (int i = 0; i < 20; i++) begin
            win();
            drive(0, 0, 0, 0, 0, 0);
            if (i == 14) exp(S_SC, PERF ? 4'hE : 0, "sat_stall_14");
        end
        win();
        drive(1, 0, 0, 0, 0, 0);
        exp(S_SC, PERF ? 4'hF : 0, "sat_stall_cnt");
        exp(S_FC, PERF ? 4'hF : 0, "sat_flush_cnt");

        win();
        win();
        @(negedge CLK);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
